// File: rtl/div_iter_if.sv
// Request/response bundle for the iterative divider.
// master: the issuing stage (drives the request and out_ready).
// slave:  the divider.
interface div_iter_if #(
  parameter int DATA_LEN = 32
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic                in_signed;
  logic [DATA_LEN-1:0] dividend;
  logic [DATA_LEN-1:0] divisor;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] quotient;
  logic [DATA_LEN-1:0] remainder;
  logic                div_zero;

  modport master (
    output flush, in_valid, in_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  flush, in_valid, in_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One trial subtraction per cycle through a shared add_with_Cout.
// Optional macro DIV_SPECIAL_FAST_EN: divide-by-zero and signed overflow
// skip the iterative phase (a single trial cycle, then FIX), so the result
// appears 2 edges after accept instead of DATA_LEN+1. Results are identical.

// Carry-out adder; with Cin=1 it computes OP_A - OP_B and Cout=1 means no borrow.
module add_with_Cout #(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] OP_A,
  input  logic [DATA_LEN-1:0] OP_B,
  input  logic                Cin,
  output logic [DATA_LEN-1:0] Sum,
  output logic                Cout,
  output logic                Overflow
);
  logic [DATA_LEN-1:0] b_eff;

  // Invert B for subtraction and form the carry chain.
  always_comb begin
    b_eff         = OP_B ^ {DATA_LEN{Cin}};
    {Cout, Sum}   = {1'b0, OP_A} + {1'b0, b_eff} + {{DATA_LEN{1'b0}}, Cin};
    Overflow      = (OP_A[DATA_LEN-1] == b_eff[DATA_LEN-1]) &&
                    (Sum[DATA_LEN-1] != OP_A[DATA_LEN-1]);
  end
endmodule

module div_iter #(
  parameter int DATA_LEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  div_iter_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LEN - 1);
  localparam logic [DATA_LEN-1:0] MOST_NEG = {1'b1, {(DATA_LEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_LEN-1:0] rem;
  logic [DATA_LEN-1:0] quo;
  logic [DATA_LEN-1:0] dvs;
  logic [DATA_LEN-1:0] a_orig;
  logic                sign_a;
  logic                sign_b;
  logic                is_signed;
  logic                dz;
  logic                ovf;

  logic [DATA_LEN-1:0] shifted;
  logic [DATA_LEN-1:0] sum;
  logic                cout;
  logic                ovf_unused;
  logic                take;

  logic                acc_sign_a;
  logic                acc_sign_b;
  logic                acc_zero;
  logic                acc_ovf;
  logic [DATA_LEN-1:0] acc_mag_a;
  logic [DATA_LEN-1:0] acc_mag_b;

  logic [DATA_LEN-1:0] fix_q;
  logic [DATA_LEN-1:0] fix_r;

  // Two's-complement negation; the most-negative value maps to itself,
  // which is exactly its unsigned magnitude.
  function automatic logic [DATA_LEN-1:0] neg2c(input logic [DATA_LEN-1:0] v);
    return ~v + DATA_LEN'(1);
  endfunction

  function automatic logic [DATA_LEN-1:0] cond_neg(input logic [DATA_LEN-1:0] v,
                                                   input logic neg);
    return neg ? neg2c(v) : v;
  endfunction

  add_with_Cout #(.DATA_LEN(DATA_LEN)) u_add (
    .OP_A     (shifted),
    .OP_B     (dvs),
    .Cin      (1'b1),
    .Sum      (sum),
    .Cout     (cout),
    .Overflow (ovf_unused)
  );

  // Trial step: the bit falling off rem makes the partial remainder
  // at least 2^DATA_LEN, so the subtraction always succeeds then.
  always_comb begin
    shifted = {rem[DATA_LEN-2:0], quo[DATA_LEN-1]};
    take    = rem[DATA_LEN-1] | cout;
  end

  // Operand decode at accept: signs, magnitudes and special cases.
  always_comb begin
    acc_sign_a = bus.in_signed & bus.dividend[DATA_LEN-1];
    acc_sign_b = bus.in_signed & bus.divisor[DATA_LEN-1];
    acc_mag_a  = cond_neg(bus.dividend, acc_sign_a);
    acc_mag_b  = cond_neg(bus.divisor, acc_sign_b);
    acc_zero   = (bus.divisor == '0);
    acc_ovf    = bus.in_signed && (bus.dividend == MOST_NEG) && (bus.divisor == '1);
  end

  // Final result selection; earlier cases take priority.
  always_comb begin
    fix_q = quo;
    fix_r = rem;
    if (dz) begin
      fix_q = '1;
      fix_r = a_orig;
    end else if (ovf) begin
      fix_q = a_orig;
      fix_r = '0;
    end else if (is_signed) begin
      fix_q = cond_neg(quo, sign_a ^ sign_b);
      fix_r = cond_neg(rem, sign_a);
    end
  end

  // Control FSM with registered handshake outputs and datapath updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      a_orig        <= '0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      is_signed     <= 1'b0;
      dz            <= 1'b0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
    end else if (bus.flush) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_orig       <= bus.dividend;
            sign_a       <= acc_sign_a;
            sign_b       <= acc_sign_b;
            is_signed    <= bus.in_signed;
            dz           <= acc_zero;
            ovf          <= acc_ovf;
            quo          <= acc_mag_a;
            dvs          <= acc_mag_b;
            rem          <= '0;
            cnt          <= '0;
`ifdef DIV_SPECIAL_FAST_EN
            // Special cases are fully decided by FIX; run one trial only.
            if (acc_zero || acc_ovf) begin
              cnt <= CNT_LAST;
            end
`endif
            bus.in_ready <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          rem <= take ? sum : shifted;
          quo <= {quo[DATA_LEN-2:0], take};
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          bus.quotient  <= fix_q;
          bus.remainder <= fix_r;
          bus.div_zero  <= dz;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter (DATA_LEN = 32).
module tb_div_iter;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  div_iter_if #(.DATA_LEN(32)) bus ();

  div_iter #(.DATA_LEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef DIV_SPECIAL_FAST_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request and return right after the accept edge.
  task automatic send(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  // Count edges from accept until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.quotient !== 32'h0) begin fails++; $display("FAIL reset_quotient got %h want 0", bus.quotient); end
    tests++; if (bus.remainder !== 32'h0) begin fails++; $display("FAIL reset_remainder got %h want 0", bus.remainder); end
    tests++; if (bus.div_zero !== 1'b0) begin fails++; $display("FAIL reset_div_zero got %b want 0", bus.div_zero); end
  endtask

  // Table of directed vectors: signed flag, operands, expected results, latency.
  task automatic test_vectors();
    logic        sg [10];
    logic [31:0] a  [10];
    logic [31:0] b  [10];
    logic [31:0] eq [10];
    logic [31:0] er [10];
    logic        ez [10];
    int          el [10];
    int          lat;
    sg[0]=0; a[0]=32'd100;       b[0]=32'd7;          eq[0]=32'd14;        er[0]=32'd2;         ez[0]=0; el[0]=33;
    sg[1]=1; a[1]=32'hFFFFFFF9;  b[1]=32'd2;          eq[1]=32'hFFFFFFFD;  er[1]=32'hFFFFFFFF;  ez[1]=0; el[1]=33;
    sg[2]=1; a[2]=32'd7;         b[2]=32'hFFFFFFFE;   eq[2]=32'hFFFFFFFD;  er[2]=32'd1;         ez[2]=0; el[2]=33;
    sg[3]=1; a[3]=32'h12345678;  b[3]=32'h0;          eq[3]=32'hFFFFFFFF;  er[3]=32'h12345678;  ez[3]=1; el[3]=SPECIAL_LAT;
    sg[4]=0; a[4]=32'h12345678;  b[4]=32'h0;          eq[4]=32'hFFFFFFFF;  er[4]=32'h12345678;  ez[4]=1; el[4]=SPECIAL_LAT;
    sg[5]=1; a[5]=32'h80000000;  b[5]=32'hFFFFFFFF;   eq[5]=32'h80000000;  er[5]=32'h0;         ez[5]=0; el[5]=SPECIAL_LAT;
    sg[6]=0; a[6]=32'h80000000;  b[6]=32'hFFFFFFFF;   eq[6]=32'h0;         er[6]=32'h80000000;  ez[6]=0; el[6]=33;
    sg[7]=0; a[7]=32'hFFFFFFFF;  b[7]=32'd1;          eq[7]=32'hFFFFFFFF;  er[7]=32'h0;         ez[7]=0; el[7]=33;
    sg[8]=0; a[8]=32'hFFFFFFFF;  b[8]=32'hFFFFFFFF;   eq[8]=32'd1;         er[8]=32'h0;         ez[8]=0; el[8]=33;
    sg[9]=1; a[9]=32'hFFFFFF9C;  b[9]=32'hFFFFFFF9;   eq[9]=32'd14;        er[9]=32'hFFFFFFFE;  ez[9]=0; el[9]=33;
    for (int i = 0; i < 10; i++) begin
      send(sg[i], a[i], b[i]);
      wait_out(lat);
      tests++; if (lat != el[i]) begin fails++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, el[i]); end
      tests++; if (bus.quotient !== eq[i]) begin fails++; $display("FAIL vec%0d_quotient got %h want %h", i, bus.quotient, eq[i]); end
      tests++; if (bus.remainder !== er[i]) begin fails++; $display("FAIL vec%0d_remainder got %h want %h", i, bus.remainder, er[i]); end
      tests++; if (bus.div_zero !== ez[i]) begin fails++; $display("FAIL vec%0d_div_zero got %b want %b", i, bus.div_zero, ez[i]); end
      pop();
      tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        fails++; $display("FAIL vec%0d_release got rdy=%b vld=%b want rdy=1 vld=0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(1'b0, 32'd1000, 32'd3);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                   bus.quotient !== 32'd333 || bus.remainder !== 32'd1) begin
        fails++; $display("FAIL hold%0d got vld=%b rdy=%b q=%h r=%h want vld=1 rdy=0 q=14d r=1",
                          i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
    end
    pop();
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL hold_release got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_flush();
    int seen;
    send(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_state got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
    tests++; if (bus.quotient !== 32'd333 || bus.remainder !== 32'd1) begin
      fails++; $display("FAIL flush_keep got q=%h r=%h want q=14d r=1", bus.quotient, bus.remainder);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen;
    send(1'b0, 32'd50, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 32'h0 ||
                 bus.remainder !== 32'h0 || bus.div_zero !== 1'b0) begin
      fails++; $display("FAIL mid_reset got rdy=%b vld=%b q=%h r=%h dz=%b want 1 0 0 0 0",
                        bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL mid_reset_no_result got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(1'b0, 32'd9, 32'd4);
    wait_out(lat);
    tests++; if (bus.quotient !== 32'd2 || bus.remainder !== 32'd1) begin
      fails++; $display("FAIL b2b_first got q=%h r=%h want q=2 r=1", bus.quotient, bus.remainder);
    end
    // Request already waiting during the handshake; accept must follow it.
    bus.in_signed = 1'b1;
    bus.dividend  = 32'hFFFFFFF7;
    bus.divisor   = 32'd4;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle got rdy=%b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_accept got rdy=%b want 0", bus.in_ready); end
    wait_out(lat);
    tests++; if (lat != 33 || bus.quotient !== 32'hFFFFFFFE || bus.remainder !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL b2b_second got lat=%0d q=%h r=%h want lat=33 q=fffffffe r=ffffffff",
                        lat, bus.quotient, bus.remainder);
    end
    pop();
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_vectors();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle restoring integer divider for the NPC EXU. It is a neighbouring stage of the ripple adder: it instantiates add_with_Cout, drives its operand and Cin inputs, and consumes its Sum and Cout outputs.
- One add_with_Cout (DATA_LEN wide) performs one trial subtraction per cycle.
- Produces RISC-V DIV/DIVU/REM/REMU results behind a valid/ready handshake on both sides.

Parameters:
- DATA_LEN, 32, operand/result width in bits; legal values are 8 or more.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- flush  input  1  synchronous abort; drops the current operation
- in_valid  input  1  request valid
- in_ready  output  1  divider idle, can accept a request
- in_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
- dividend  input  DATA_LEN  operand A
- divisor  input  DATA_LEN  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  DATA_LEN  quotient result
- remainder  output  DATA_LEN  remainder result
- div_zero  output  1  divisor was zero for this result

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, iteration counter=0.
- States:
  - IDLE: in_ready=1.
  - CALC: DATA_LEN cycles.
  - FIX: 1 cycle.
  - DONE: out_valid=1.
- in_ready=1 only in IDLE. Accept when in_valid&in_ready: latch operands, in_signed, the sign of each operand, div_zero=(divisor==0), and ovf=(signed & dividend==100..0 & divisor==all-ones). Then go to CALC.
- Signed operands are converted to magnitudes at accept using two's-complement negation. Most-negative stays 100..0 and is treated as unsigned.
- Registers: rem (DATA_LEN) and quo (DATA_LEN), quo initialised to the dividend magnitude and rem to 0.
- CALC, each cycle:
  - shifted = {rem[DATA_LEN-2:0], quo[DATA_LEN-1]}.
  - Adder inputs: OP_A=shifted, OP_B=divisor magnitude, Cin=1 (subtract).
  - If the bit shifted out of rem was 1 or Cout=1: rem<=Sum, quo<={quo[DATA_LEN-2:0],1}.
  - Otherwise: rem<=shifted, quo<={quo[DATA_LEN-2:0],0}.
  - The adder overflow output is unused.
- Counter counts 0..DATA_LEN-1. The last CALC cycle moves to FIX.
- FIX: priority order, first match wins:
  - div_zero: quotient=all-ones, remainder=original dividend, for both signed and unsigned.
  - ovf: quotient=original dividend, remainder=0.
  - signed: quotient negated if sign(A)^sign(B); remainder negated if sign(A).
  - unsigned: raw quo/rem.
  - Then go to DONE.
- DONE: out_valid=1. quotient, remainder and div_zero are held stable until out_valid&out_ready, then go to IDLE.
- Latency: out_valid rises DATA_LEN+1 rising edges after the accept edge. The next accept is possible no earlier than the cycle after the output handshake. There is no overlap of requests.
- flush: synchronous and has highest priority over accept and the output handshake. In any state the next state is IDLE and out_valid=0. quotient, remainder and div_zero keep their old values.
- rst_n low mid-operation: immediate return to reset values. No result is produced.
- in_valid while busy: ignored because in_ready=0. The upstream stage must hold the request.

Optional Feature:
- Macro DIV_SPECIAL_FAST_EN.
- Defined: when div_zero or ovf is detected at accept, skip CALC and go directly to FIX. out_valid then rises 2 edges after accept.
- Undefined: special cases run the full DATA_LEN CALC iterations. The FIX override still produces the same results, with latency DATA_LEN+1.
- Result values are identical in both builds; only latency differs.

Test Plan:
- Unsigned, DATA_LEN=32: in_signed=0, dividend=100, divisor=7 -> quotient=14, remainder=2, div_zero=0. out_valid is first seen 33 edges after accept.
- Signed: dividend=-7 (0xFFFFFFF9), divisor=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also dividend=7, divisor=-2 -> quotient=-3, remainder=1.
- Divide by zero: dividend=0x12345678, divisor=0, signed and unsigned -> quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1. Latency is 2 edges with DIV_SPECIAL_FAST_EN and 33 edges without.
- Signed overflow: dividend=0x80000000, divisor=0xFFFFFFFF, in_signed=1 -> quotient=0x80000000, remainder=0. The same operands unsigned -> quotient=0, remainder=0x80000000.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE on the next edge.
  - flush=1 on CALC cycle 10 -> IDLE next edge, in_ready=1, no out_valid.
  - rst_n pulsed low mid-CALC -> all outputs at reset values immediately.
- Max unsigned: dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. dividend=0xFFFFFFFF, divisor=0xFFFFFFFF -> quotient=1, remainder=0.
